// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter and sequencer for the single-ported data memory.
//   Requester 0 is the CPU load/store path and requester 1 is the loader/DMA
//   port. One transaction at a time: the winning command is latched in IDLE,
//   held on the memory side for MEM_LAT cycles (ACCESS), then acknowledged
//   for exactly one cycle (DONE). Stores produce a single mem_we cycle on the
//   last ACCESS cycle.
//
//   Parameters: ADDR_W, DATA_W, MEM_LAT (1..15, 4-bit access counter).
//   Build option: DMEM_ARB_ROUND_ROBIN_EN -- when defined, simultaneous
//   requests alternate via a priority pointer; otherwise the CPU always wins.
//
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     cpu_req/we/addr/wdata      CPU command (req held until cpu_ack)
//     cpu_rdata, cpu_ack         CPU load data (held), one-cycle completion
//     dma_*                      same set for the DMA/loader requester
//     mem_addr/we/wdata          data memory command
//     mem_rdata                  data memory combinational read data
//     busy                       high in ACCESS and DONE
//     grant_id                   owner of current/last transaction (1 = DMA)
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              win;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Preferred requester on a tie (0 = CPU); set to the loser at each grant.
    logic prio_q, prio_d;

    always_comb begin
        win = 1'b0;
        if (cpu_req && dma_req) begin
            win = prio_q;
        end else begin
            win = dma_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        win = !cpu_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        grant_d     = grant_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        prio_d      = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_d = win;
                    we_d    = win ? dma_we    : cpu_we;
                    addr_d  = win ? dma_addr  : cpu_addr;
                    wdata_d = win ? dma_wdata : cpu_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    prio_d  = !win;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        if (grant_q) begin
                            dma_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            grant_q     <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            grant_q     <= grant_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Memory side is driven straight from the latched command, so it holds
    // its last value outside ACCESS. The write strobe fires only on the final
    // ACCESS cycle to give one write per store.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == ACCESS) && we_q && (cnt_q == 4'd0);

    assign cpu_ack   = (state_q == DONE) && !grant_q;
    assign dma_ack   = (state_q == DONE) &&  grant_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances with MEM_LAT = 1, 3 and 4, each
// attached to a small behavioural memory. Expected completions (requester,
// ack cycle, read data, write address/data) are queued when a request is
// driven and compared when the matching ack appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;

    logic [2:0]  cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr [3];
    logic [31:0] cpu_wdata[3];
    logic [31:0] dma_addr [3];
    logic [31:0] dma_wdata[3];
    logic [31:0] cpu_rdata[3];
    logic [31:0] dma_rdata[3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic [31:0] mem_rdata[3];
    logic [2:0]  cpu_ack, dma_ack, mem_we, busy, grant_id;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned L = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
        logic [31:0] mem [64];

        assign mem_rdata[k] = mem[mem_addr[k][5:0]];
        always @(posedge clk) begin
            if (mem_we[k]) mem[mem_addr[k][5:0]] <= mem_wdata[k];
        end

        dmem_arbiter #(
            .ADDR_W (32),
            .DATA_W (32),
            .MEM_LAT(L)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .cpu_req  (cpu_req[k]),
            .cpu_we   (cpu_we[k]),
            .cpu_addr (cpu_addr[k]),
            .cpu_wdata(cpu_wdata[k]),
            .cpu_rdata(cpu_rdata[k]),
            .cpu_ack  (cpu_ack[k]),
            .dma_req  (dma_req[k]),
            .dma_we   (dma_we[k]),
            .dma_addr (dma_addr[k]),
            .dma_wdata(dma_wdata[k]),
            .dma_rdata(dma_rdata[k]),
            .dma_ack  (dma_ack[k]),
            .mem_addr (mem_addr[k]),
            .mem_we   (mem_we[k]),
            .mem_wdata(mem_wdata[k]),
            .mem_rdata(mem_rdata[k]),
            .busy     (busy[k]),
            .grant_id (grant_id[k])
        );
    end

    typedef struct {
        bit          id;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow  [3][64];
    logic [31:0] model_rd[3][2];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue an expected completion and advance the reference model.
    task automatic expect_txn(input int k, input bit id, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int exp_cyc);
        exp_t e;
        e.id    = id;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.cyc   = exp_cyc;
        if (we) begin
            e.rdata = model_rd[k][id];
            shadow[k][addr[5:0]] = wdata;
        end else begin
            e.rdata = shadow[k][addr[5:0]];
            model_rd[k][id] = e.rdata;
        end
        sb.push_back(e);
    endtask

    task automatic drive_req(input int k, input bit id, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (!id) begin
            cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
        end else begin
            dma_req[k] = 1'b1; dma_we[k] = we; dma_addr[k] = addr; dma_wdata[k] = wdata;
        end
    endtask

    task automatic launch(input int k, input bit id, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_cyc);
        drive_req(k, id, we, addr, wdata);
        expect_txn(k, id, we, addr, wdata, exp_cyc);
    endtask

    // Watch instance k until every queued completion has been seen. A
    // requester's req is held for rep0/rep1 transactions, then dropped.
    // cpu_addr is overwritten with chg_addr at cycle chg_at (0 = never).
    task automatic drain(input int k, input int rep0, input int rep1,
                         input int chg_at, input logic [31:0] chg_addr);
        int          rep[2];
        bit          drop[2];
        int          we_cnt   = 0;
        int          busy_cnt = 0;
        logic [31:0] we_addr  = '0;
        logic [31:0] we_data  = '0;
        bit          id;
        exp_t        e;
        rep[0] = rep0;
        rep[1] = rep1;
        for (int n = 0; n < 80 && sb.size() > 0; n++) begin
            drop[0] = 1'b0;
            drop[1] = 1'b0;
            @(negedge clk);
            if (mem_we[k]) begin
                we_cnt++;
                we_addr = mem_addr[k];
                we_data = mem_wdata[k];
            end
            if (busy[k]) busy_cnt++;
            if (cpu_ack[k] || dma_ack[k]) begin
                check("ack_excl", 64'(cpu_ack[k] & dma_ack[k]), 64'd0);
                id = dma_ack[k];
                e  = sb.pop_front();
                check("ack_id",    64'(id), 64'(e.id));
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
                check("grant_id",  64'(grant_id[k]), 64'(e.id));
                check("addr_hold", 64'(mem_addr[k]), 64'(e.addr));
                check("busy_len",  64'(busy_cnt), 64'(lat_of(k) + 1));
                check("rdata", 64'(id ? dma_rdata[k] : cpu_rdata[k]), 64'(e.rdata));
                if (e.we) begin
                    check("we_pulses", 64'(we_cnt), 64'd1);
                    check("we_addr",   64'(we_addr), 64'(e.addr));
                    check("we_data",   64'(we_data), 64'(e.wdata));
                end else begin
                    check("we_pulses", 64'(we_cnt), 64'd0);
                end
                we_cnt   = 0;
                busy_cnt = 0;
                if (rep[id] > 1) rep[id]--;
                else drop[id] = 1'b1;
            end
            @(posedge clk); #1;
            if (drop[0]) cpu_req[k] = 1'b0;
            if (drop[1]) dma_req[k] = 1'b0;
            if (chg_at != 0 && cyc == chg_at) cpu_addr[k] = chg_addr;
        end
        if (sb.size() != 0) begin
            check("ack_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        cpu_req[k] = 1'b0;
        dma_req[k] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_mem_addr",  64'(mem_addr[k]), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata[k]), 64'd0);
        check("rst_rdata",     {cpu_rdata[k], dma_rdata[k]}, 64'd0);
        check("rst_ctl", 64'({mem_we[k], busy[k], grant_id[k], cpu_ack[k], dma_ack[k]}), 64'd0);
    endtask

    initial begin
        int  t;
        bit  saw_we;
        bit  saw_ack;

        rst_n   = 1'b0;
        cpu_req = '0; cpu_we = '0; dma_req = '0; dma_we = '0;
        for (int k = 0; k < 3; k++) begin
            cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dma_addr[k] = '0; dma_wdata[k] = '0;
            model_rd[k][0] = '0;
            model_rd[k][1] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MEM_LAT=1: CPU store then load.
        launch(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, cyc + 2);
        drain(0, 1, 1, 0, '0);
        launch(0, 1'b0, 1'b0, 32'h10, '0, cyc + 2);
        drain(0, 1, 1, 0, '0);

        // MEM_LAT=4: DMA preload then DMA load.
        launch(2, 1'b1, 1'b1, 32'h20, 32'h12345678, cyc + 5);
        drain(2, 1, 1, 0, '0);
        launch(2, 1'b1, 1'b0, 32'h20, '0, cyc + 5);
        drain(2, 1, 1, 0, '0);

        // MEM_LAT=1 contention: both requests in the same IDLE cycle.
        t = cyc;
        drive_req(0, 1'b0, 1'b0, 32'h10, '0);
        drive_req(0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        expect_txn(0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, t + 2);
        expect_txn(0, 1'b0, 1'b0, 32'h10, '0, t + 5);
`else
        expect_txn(0, 1'b0, 1'b0, 32'h10, '0, t + 2);
        expect_txn(0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, t + 5);
`endif
        drain(0, 1, 1, 0, '0);
        launch(0, 1'b1, 1'b0, 32'h24, '0, cyc + 2);
        drain(0, 1, 1, 0, '0);

        // Both requesters hold req for two transactions each.
        t = cyc;
        drive_req(0, 1'b0, 1'b0, 32'h10, '0);
        drive_req(0, 1'b1, 1'b0, 32'h24, '0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        expect_txn(0, 1'b0, 1'b0, 32'h10, '0, t + 2);
        expect_txn(0, 1'b1, 1'b0, 32'h24, '0, t + 5);
        expect_txn(0, 1'b0, 1'b0, 32'h10, '0, t + 8);
        expect_txn(0, 1'b1, 1'b0, 32'h24, '0, t + 11);
`else
        expect_txn(0, 1'b0, 1'b0, 32'h10, '0, t + 2);
        expect_txn(0, 1'b0, 1'b0, 32'h10, '0, t + 5);
        expect_txn(0, 1'b1, 1'b0, 32'h24, '0, t + 8);
        expect_txn(0, 1'b1, 1'b0, 32'h24, '0, t + 11);
`endif
        drain(0, 2, 2, 0, '0);

        // MEM_LAT=3: cpu_addr changes during ACCESS; later store keeps rdata.
        t = cyc;
        launch(1, 1'b0, 1'b1, 32'h10, 32'h11112222, t + 4);
        drain(1, 1, 1, t + 1, 32'h30);
        launch(1, 1'b0, 1'b0, 32'h10, '0, cyc + 4);
        drain(1, 1, 1, 0, '0);
        launch(1, 1'b0, 1'b1, 32'h10, 32'h33334444, cyc + 4);
        drain(1, 1, 1, 0, '0);
        launch(1, 1'b0, 1'b0, 32'h10, '0, cyc + 4);
        drain(1, 1, 1, 0, '0);

        // MEM_LAT=3: reset during the second ACCESS cycle of a store.
        saw_we  = 1'b0;
        saw_ack = 1'b0;
        drive_req(1, 1'b0, 1'b1, 32'h14, 32'hA5A5A5A5);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            saw_we  |= mem_we[1];
            saw_ack |= cpu_ack[1] | dma_ack[1];
            @(posedge clk); #1;
            if (n == 1) begin
                rst_n      = 1'b0;
                cpu_req[1] = 1'b0;
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model_rd[k][0] = '0;
            model_rd[k][1] = '0;
        end
        @(negedge clk);
        check_reset_outputs(1);
        for (int n = 0; n < 6; n++) begin
            saw_we  |= mem_we[1];
            saw_ack |= cpu_ack[1] | dma_ack[1];
            @(negedge clk);
        end
        check("rst_abort_we",  64'(saw_we),  64'd0);
        check("rst_abort_ack", 64'(saw_ack), 64'd0);
        @(posedge clk); #1;

        // Recovery after the aborted store.
        launch(1, 1'b0, 1'b0, 32'h10, '0, cyc + 4);
        drain(1, 1, 1, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported data memory.
- Requester 0 is the CPU load/store path; requester 1 is a loader/DMA port used to preload or inspect data memory.
- Serialises accesses, holds the memory-side address/data stable for a configurable access latency, issues a single write strobe per store, and returns read data with a one-cycle acknowledge.
- The CPU stalls its pc update while cpu_req is high and cpu_ack is low.

Parameters:
- ADDR_W, 32: address width, matching the adder output feeding data memory.
- DATA_W, 32: data word width.
- MEM_LAT, 1: memory access cycles per transaction. Legal range 1..15; the counter is 4 bits.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- rst_n  in  1  synchronous, active-low reset; sampled on the clk posedge.
- cpu_req  in  1  CPU request; level signal held until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load result; valid while cpu_ack is high, held afterwards.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- dma_req / dma_we / dma_addr / dma_wdata / dma_rdata / dma_ack: same as the cpu_* ports, for requester 1.
- mem_addr  out  ADDR_W  address to data memory.
- mem_we  out  1  data memory write enable.
- mem_wdata  out  DATA_W  data memory write data.
- mem_rdata  in  DATA_W  data memory read data (combinational read).
- busy  out  1  high in ACCESS and DONE.
- grant_id  out  1  owner of the current or last transaction (0 = CPU, 1 = DMA).

Behaviour:
- Reset (rst_n = 0 at a posedge):
  - state = IDLE; all outputs 0; latched command registers 0; priority pointer = CPU.
  - Reset mid-transaction aborts it: no ack, no further mem_we.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise select a winner and latch its we/addr/wdata plus grant_id. Load cnt = MEM_LAT-1 and go to ACCESS.
  - Requests are sampled only in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched_we AND (cnt == 0), so exactly one write cycle per store.
  - While cnt != 0: cnt decrements.
  - When cnt == 0: for a load, capture mem_rdata into the winner's rdata register; go to DONE.
- DONE:
  - The winner's ack is high for exactly this cycle; mem_we = 0; next state is IDLE.
  - A requester still holding req in the following IDLE cycle is treated as a new request.
- Outputs outside ACCESS:
  - mem_addr and mem_wdata hold their last latched values.
  - mem_we = 0 in IDLE and DONE.
- Read-data registers: *_rdata is updated only by that requester's loads; stores leave it unchanged.
- Latency and throughput:
  - A request asserted in IDLE cycle t gives ack in cycle t+MEM_LAT+1.
  - Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Arbitration (default build): fixed priority, CPU wins when both req are high.
- Never assert cpu_ack and dma_ack in the same cycle.
- Requester inputs may change while not granted. Changes to the granted requester's fields during ACCESS are ignored, because the command is latched.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests, the requester not granted last wins.
  - The pointer updates at entry to ACCESS and resets to CPU.
  - A lone request is always granted regardless of the pointer.
- Undefined: fixed CPU priority as described above; no pointer register is synthesised.

Test Plan:
- Reset mid-store: MEM_LAT=3, CPU store issued, rst_n=0 during the 2nd ACCESS cycle -> mem_we never asserts, no cpu_ack, all outputs 0 next cycle.
- CPU store then load:
  - Store addr 0x10, data 0xDEADBEEF, MEM_LAT=1 -> mem_we high for exactly 1 cycle with mem_addr 0x10; cpu_ack 2 cycles after req.
  - Load from 0x10 -> cpu_rdata = 0xDEADBEEF with cpu_ack.
- Latency sweep: MEM_LAT=4, DMA load from 0x20 holding 0x12345678 -> dma_ack exactly 5 cycles after req; busy high 5 cycles; dma_rdata = 0x12345678.
- Contention, default build: both req high in the same IDLE cycle -> CPU served first, DMA ack 3 cycles after cpu_ack (MEM_LAT=1); acks never overlap.
- Contention with DMEM_ARB_ROUND_ROBIN_EN: both requesters continuously requesting -> grants alternate CPU, DMA, CPU, DMA; grant_id toggles every transaction.
- Hold/ignore: the CPU changes cpu_addr from 0x10 to 0x30 during ACCESS -> mem_addr stays 0x10 until DONE; cpu_rdata is unchanged by a subsequent CPU store.
